vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL provide parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL provide parameter H_FP, H_SW, H_BP, defaults 16, 96, 48, horizontal front porch, sync width and back porch in pixels.
REQ-003 SHALL provide parameter V_VIS, default 480, visible lines per frame.
REQ-004 SHALL provide parameter V_FP, V_SW, V_BP, defaults 10, 2, 33, vertical front porch, sync width and back porch in lines.
REQ-005 SHALL provide parameter CE_DIV, default 2, CLK cycles per pixel (legal range 1..16).
REQ-006 Port: CLK  input  1  system clock; the single clock, all logic on its rising edge.
REQ-007 Port: RST  input  1  synchronous, active-high reset.
REQ-008 Port: CE  output  1  pixel strobe to the image source stage.
REQ-009 Port: PIX  output  10  current pixel column, 0..H_TOT-1.
REQ-010 Port: LINE  output  10  current line, 0..V_TOT-1.
REQ-011 Port: HSYNC  output  1  horizontal sync, active low.
REQ-012 Port: VSYNC  output  1  vertical sync, active low.
REQ-013 Port: DE  output  1  display enable, high while the visible pixel is on the RGB bus.
REQ-014 Port: FRAME  output  1  one-CLK frame-start pulse.

Function
REQ-015 H_TOT SHALL equal H_VIS+H_FP+H_SW+H_BP (800 at defaults), and V_TOT SHALL equal V_VIS+V_FP+V_SW+V_BP (525 at defaults).
REQ-016 A divider counter d SHALL count 0..CE_DIV-1 and wrap, advancing on every CLK.
REQ-017 CE SHALL be the decode d==CE_DIV-1, giving exactly one high CLK cycle in every CE_DIV cycles; with CE_DIV=1, CE SHALL be constantly high outside reset.
REQ-018 PIX and LINE SHALL change only on CLK edges where CE=1.
REQ-019 On a CE edge, PIX SHALL go to PIX+1, or to 0 when PIX==H_TOT-1.
REQ-020 LINE SHALL increment only on the CE edge where PIX wraps, and SHALL wrap to 0 when it is at V_TOT-1 at that edge.
REQ-021 HSYNC, VSYNC and DE SHALL be registered on CE edges from the pre-edge PIX/LINE, giving one pixel of latency that matches the registered RGB of the downstream image source.
REQ-022 HSYNC SHALL be registered 0 iff H_VIS+H_FP <= PIX < H_VIS+H_FP+H_SW (656..751 at defaults).
REQ-023 VSYNC SHALL be registered 0 iff V_VIS+V_FP <= LINE < V_VIS+V_FP+V_SW (490..491 at defaults); it is evaluated per pixel, so its edges align with HSYNC pixel timing.
REQ-024 DE SHALL be registered 1 iff PIX<H_VIS and LINE<V_VIS.
REQ-025 FRAME SHALL be 1 for exactly one CLK following the CE edge on which PIX==H_TOT-1 and LINE==V_TOT-1 (counters wrap to 0,0), and 0 otherwise.
REQ-026 Between CE edges, HSYNC, VSYNC, DE, PIX and LINE SHALL hold their values.
REQ-027 Counter widths SHALL be 10 bits, and parameter sets with H_TOT or V_TOT > 1024 SHALL be unsupported.

Reset
REQ-028 While RST=1 at a CLK edge: d=0, PIX=0, LINE=0, HSYNC=1, VSYNC=1, DE=0, FRAME=0.
REQ-029 CE SHALL be 0 throughout reset when CE_DIV>1, and SHALL be forced to 0 during reset when CE_DIV=1.
REQ-030 RST asserted mid-line or mid-frame SHALL take priority over CE; after release, counting SHALL restart from PIX=0, LINE=0, with the first CE on CLK cycle CE_DIV-1 after release.
REQ-031 FRAME SHALL NOT pulse on reset release, only on a genuine counter wrap.

Verification
REQ-032 Reset release, CE_DIV=2 -> CE high on alternate CLKs, first high 1 CLK after release; PIX=1 after 2nd CLK edge post-release, PIX=2 after 4th.
REQ-033 Run one full line -> PIX sequence 0..799 then 0; LINE 0->1 on the wrap edge only; HSYNC low for exactly 96 CE periods, first low in the CE period after PIX=656.
REQ-034 Run one full frame -> VSYNC low for exactly 2*800 CE periods starting after LINE=490,PIX=0 is sampled; FRAME single CLK pulse after the 799/524 edge; 640*480 CE periods with DE=1.
REQ-035 Check DE boundary -> DE registered 1 from PIX=639,LINE=479 and 0 from PIX=640 and from LINE=480,PIX=0.
REQ-036 Assert RST for 1 CLK at PIX=400, LINE=300 -> next cycle PIX=0, LINE=0, HSYNC=VSYNC=1, DE=0, no FRAME pulse; sequence then matches the REQ-032 startup.
REQ-037 CE_DIV=1, 4 -> CE duty 1/1 and 1/4 respectively; line period 800 and 3200 CLKs.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator.
// Produces a pixel strobe (CE) from a free-running divider, pixel/line
// counters that advance on that strobe, and HSYNC/VSYNC/DE registered one
// pixel behind the counters so they line up with a registered RGB stage.
// Counters are 10 bits; geometries with H_TOT or V_TOT above 1024 are not
// supported.
module vga_timing #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SW   = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SW   = 2,
    parameter int V_BP   = 33,
    parameter int CE_DIV = 2
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       CE,
    output logic [9:0] PIX,
    output logic [9:0] LINE,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       DE,
    output logic       FRAME
);

    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

    // Comparisons are done at 11 bits so a geometry totalling exactly 1024
    // does not alias its end-of-range constants back to zero.
    localparam logic [3:0]  DIV_LAST = 4'(CE_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
    localparam logic [10:0] H_VIS_C  = 11'(H_VIS);
    localparam logic [10:0] V_VIS_C  = 11'(V_VIS);
    localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SW);
    localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SW);

    logic [3:0]  div_q, div_d;
    logic [9:0]  pix_q, pix_d;
    logic [9:0]  line_q, line_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        frame_q, frame_d;

    logic        ce_tick;
    logic        pix_wrap;
    logic        line_wrap;
    logic [10:0] pix_x;
    logic [10:0] line_x;

    assign ce_tick   = (div_q == DIV_LAST);
    assign pix_x     = {1'b0, pix_q};
    assign line_x    = {1'b0, line_q};
    assign pix_wrap  = (pix_x == H_LAST);
    assign line_wrap = (line_x == V_LAST);

    // The strobe is masked by reset so CE_DIV=1 does not leak a tick while held.
    assign CE = ce_tick & ~RST;

    // Divider: counts 0..CE_DIV-1 on every clock and wraps.
    always_comb begin
        div_d = div_q + 4'd1;
        if (ce_tick) begin
            div_d = 4'd0;
        end
    end

    // Next raster position and one-pixel-delayed sync/enable decodes.
    always_comb begin
        pix_d   = pix_q;
        line_d  = line_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        frame_d = 1'b0;
        if (ce_tick) begin
            pix_d   = pix_wrap ? 10'd0 : pix_q + 10'd1;
            if (pix_wrap) begin
                line_d = line_wrap ? 10'd0 : line_q + 10'd1;
            end
            hsync_d = !((pix_x >= HS_START) && (pix_x < HS_END));
            vsync_d = !((line_x >= VS_START) && (line_x < VS_END));
            de_d    = (pix_x < H_VIS_C) && (line_x < V_VIS_C);
            frame_d = pix_wrap && line_wrap;
        end
    end

    // State registers; reset wins over any pending strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q   <= 4'd0;
            pix_q   <= 10'd0;
            line_q  <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            frame_q <= frame_d;
        end
    end

    assign PIX   = pix_q;
    assign LINE  = line_q;
    assign HSYNC = hsync_q;
    assign VSYNC = vsync_q;
    assign DE    = de_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: four instances (default geometry at CE_DIV 2, 1, 4
// and a small geometry at CE_DIV 3) share clock and reset. A closed-form
// model derives every output from the number of clocks since reset release;
// per-line and per-frame window counts pin the model to hand-derived totals.
module tb_vga_timing;

    localparam int N = 4;

    int hv_a  [N] = '{640, 640, 640, 8};
    int hf_a  [N] = '{16, 16, 16, 2};
    int hsw_a [N] = '{96, 96, 96, 3};
    int hb_a  [N] = '{48, 48, 48, 4};
    int vv_a  [N] = '{480, 480, 480, 5};
    int vf_a  [N] = '{10, 10, 10, 1};
    int vsw_a [N] = '{2, 2, 2, 2};
    int vb_a  [N] = '{33, 33, 33, 3};
    int dv_a  [N] = '{2, 1, 4, 3};

    // Clock and reset
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic       ce_w   [N];
    logic [9:0] pix_w  [N];
    logic [9:0] line_w [N];
    logic       hs_w   [N];
    logic       vs_w   [N];
    logic       de_w   [N];
    logic       fr_w   [N];

    vga_timing u0 (
        .CLK(CLK), .RST(RST), .CE(ce_w[0]), .PIX(pix_w[0]), .LINE(line_w[0]),
        .HSYNC(hs_w[0]), .VSYNC(vs_w[0]), .DE(de_w[0]), .FRAME(fr_w[0])
    );

    vga_timing #(.CE_DIV(1)) u1 (
        .CLK(CLK), .RST(RST), .CE(ce_w[1]), .PIX(pix_w[1]), .LINE(line_w[1]),
        .HSYNC(hs_w[1]), .VSYNC(vs_w[1]), .DE(de_w[1]), .FRAME(fr_w[1])
    );

    vga_timing #(.CE_DIV(4)) u2 (
        .CLK(CLK), .RST(RST), .CE(ce_w[2]), .PIX(pix_w[2]), .LINE(line_w[2]),
        .HSYNC(hs_w[2]), .VSYNC(vs_w[2]), .DE(de_w[2]), .FRAME(fr_w[2])
    );

    vga_timing #(
        .H_VIS(8), .H_FP(2), .H_SW(3), .H_BP(4),
        .V_VIS(5), .V_FP(1), .V_SW(2), .V_BP(3), .CE_DIV(3)
    ) u3 (
        .CLK(CLK), .RST(RST), .CE(ce_w[3]), .PIX(pix_w[3]), .LINE(line_w[3]),
        .HSYNC(hs_w[3]), .VSYNC(vs_w[3]), .DE(de_w[3]), .FRAME(fr_w[3])
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs as a function of clocks since reset release.
    // Packing: {CE, PIX[9:0], LINE[9:0], HSYNC, VSYNC, DE, FRAME}.
    function automatic logic [24:0] model_out(input int i, input int t, input logic rst);
        int ht, vt, tot, d, k, p, q, qp, ql, hs0, vs0;
        logic ce, hs, vs, de, fr;
        logic [9:0] px, ln;
        ht  = hv_a[i] + hf_a[i] + hsw_a[i] + hb_a[i];
        vt  = vv_a[i] + vf_a[i] + vsw_a[i] + vb_a[i];
        tot = ht * vt;
        d   = dv_a[i];
        k   = t / d;
        p   = k % tot;
        px  = 10'(p % ht);
        ln  = 10'(p / ht);
        ce  = !rst && ((t % d) == d - 1);
        if (k == 0) begin
            hs = 1'b1;
            vs = 1'b1;
            de = 1'b0;
        end else begin
            q   = (p + tot - 1) % tot;
            qp  = q % ht;
            ql  = q / ht;
            hs0 = hv_a[i] + hf_a[i];
            vs0 = vv_a[i] + vf_a[i];
            hs  = !((qp >= hs0) && (qp < hs0 + hsw_a[i]));
            vs  = !((ql >= vs0) && (ql < vs0 + vsw_a[i]));
            de  = (qp < hv_a[i]) && (ql < vv_a[i]);
        end
        fr = (k > 0) && ((t % d) == 0) && (p == 0);
        return {ce, px, ln, hs, vs, de, fr};
    endfunction

    // Scoreboard: model advances on each edge and queues the expected outputs.
    logic [24:0] exp_q[$];
    int          t_cnt [N];
    bit          started = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            started = 1'b1;
            for (int i = 0; i < N; i++) t_cnt[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) t_cnt[i] = t_cnt[i] + 1;
        end
        #2;
        if (started) begin
            for (int i = 0; i < N; i++) exp_q.push_back(model_out(i, t_cnt[i], RST));
        end
    end

    // Window accumulators for per-line (u0..u2) and per-frame (u3) totals.
    int         lw_cnt [3];
    int         lw_hs  [3];
    int         lw_de  [3];
    bit         lw_ok  [3];
    int         line_checks [3];
    logic [9:0] prev_line [3];
    int         fw_cnt, fw_de, fw_hs, fw_vs, frame_checks;
    bit         fw_ok = 1'b0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            lw_ok[i] = 1'b0;
            line_checks[i] = 0;
        end
        frame_checks = 0;
    end

    // Compare process: every cycle, every instance, sampled on the falling edge.
    always @(negedge CLK) begin
        logic [24:0] e, a;
        if (exp_q.size() >= N) begin
            for (int i = 0; i < N; i++) begin
                e = exp_q.pop_front();
                a = {ce_w[i], pix_w[i], line_w[i], hs_w[i], vs_w[i], de_w[i], fr_w[i]};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL u%0d outputs: got %h expected %h at %0t", i, a, e, $time);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (started && line_w[i] != prev_line[i]) begin
                if (line_w[i] == prev_line[i] + 10'd1) begin
                    if (lw_ok[i]) begin
                        check($sformatf("u%0d line period", i), lw_cnt[i], 800 * dv_a[i]);
                        check($sformatf("u%0d hsync low pixels", i), lw_hs[i], 96);
                        check($sformatf("u%0d de pixels", i), lw_de[i], 640);
                        line_checks[i]++;
                    end
                    lw_ok[i] = 1'b1;
                end
                lw_cnt[i] = 0;
                lw_hs[i]  = 0;
                lw_de[i]  = 0;
            end
            lw_cnt[i]++;
            if (ce_w[i] && !hs_w[i]) lw_hs[i]++;
            if (ce_w[i] && de_w[i])  lw_de[i]++;
            prev_line[i] = line_w[i];
            if (RST) lw_ok[i] = 1'b0;
        end
        if (fr_w[3] === 1'b1) begin
            if (fw_ok) begin
                check("u3 frame period", fw_cnt, 17 * 11 * 3);
                check("u3 de pixels", fw_de, 8 * 5);
                check("u3 hsync low pixels", fw_hs, 3 * 11);
                check("u3 vsync low pixels", fw_vs, 2 * 17);
                frame_checks++;
            end
            fw_ok  = 1'b1;
            fw_cnt = 0;
            fw_de  = 0;
            fw_hs  = 0;
            fw_vs  = 0;
        end
        fw_cnt++;
        if (ce_w[3] && de_w[3])  fw_de++;
        if (ce_w[3] && !hs_w[3]) fw_hs++;
        if (ce_w[3] && !vs_w[3]) fw_vs++;
        if (RST) fw_ok = 1'b0;
    end

    // Driver: hold reset for n edges, release just after the last one.
    task automatic apply_reset(input int n);
        #1 RST = 1'b1;
        repeat (n) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic check_reset_state(input int i, input int exp_ce);
        check($sformatf("u%0d rst ce", i), int'(ce_w[i]), exp_ce);
        check($sformatf("u%0d rst pix", i), int'(pix_w[i]), 0);
        check($sformatf("u%0d rst line", i), int'(line_w[i]), 0);
        check($sformatf("u%0d rst hsync", i), int'(hs_w[i]), 1);
        check($sformatf("u%0d rst vsync", i), int'(vs_w[i]), 1);
        check($sformatf("u%0d rst de", i), int'(de_w[i]), 0);
        check($sformatf("u%0d rst frame", i), int'(fr_w[i]), 0);
    endtask

    initial begin
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        // Startup sequence at CE_DIV=2, plus CE_DIV=1 strobe right away.
        @(negedge CLK);
        check_reset_state(0, 0);
        check("u1 ce at release", int'(ce_w[1]), 1);
        @(negedge CLK);
        check("u0 first ce", int'(ce_w[0]), 1);
        check("u0 pix before first ce edge", int'(pix_w[0]), 0);
        @(negedge CLK);
        check("u0 pix after 2 edges", int'(pix_w[0]), 1);
        check("u0 ce alternates", int'(ce_w[0]), 0);
        repeat (2) @(negedge CLK);
        check("u0 pix after 4 edges", int'(pix_w[0]), 2);

        repeat (8000) @(posedge CLK);

        // Random mid-line / mid-frame resets.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(100, 2500)) @(posedge CLK);
            apply_reset($urandom_range(1, 3));
            @(negedge CLK);
            check_reset_state(0, 0);
            check_reset_state(3, 0);
            check("u1 ce after reset", int'(ce_w[1]), 1);
        end

        repeat (9000) @(posedge CLK);

        check("u0 line windows seen", int'(line_checks[0] > 0), 1);
        check("u1 line windows seen", int'(line_checks[1] > 0), 1);
        check("u2 line windows seen", int'(line_checks[2] > 0), 1);
        check("u3 frame windows seen", int'(frame_checks > 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
